// File: rtl/mpu_cmd_sequencer.sv
// mpu_cmd_sequencer: fetches a command's register address/write data from ROM and runs one I2C transaction
module mpu_cmd_sequencer #(
    parameter int ADDR_ROM_SZ = 4,
    parameter int DATA_ROM_SZ = 8,
    parameter int MAX_BYTES   = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ADDR_ROM_SZ-1:0] I_CMD,
    input  logic                   I_CMD_VALID,
    output logic                   O_BUSY,
    output logic [8*MAX_BYTES-1:0] O_DATA,
    output logic                   O_DATA_VALID,
    output logic                   O_ERR,
    output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
    input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM,
    input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM_ECHO,
    output logic                   O_I2C_START,
    output logic                   O_I2C_RW,
    output logic [7:0]             O_I2C_REG_ADDR,
    output logic [7:0]             O_I2C_WDATA,
    output logic [2:0]             O_I2C_NBYTES,
    input  logic                   I_I2C_BUSY,
    input  logic [7:0]             I_I2C_RDATA,
    input  logic                   I_I2C_RVALID,
    input  logic                   I_I2C_DONE,
    input  logic                   I_I2C_NACK
);
    typedef enum logic [3:0] {IDLE, RA_WAIT, RA_LATCH, WD_WAIT, WD_LATCH, ISSUE, XFER, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [ADDR_ROM_SZ-1:0] cmd;
    logic [7:0] reg_addr, wdata;
    logic [2:0] cnt, cnt_nx, nbytes;
    logic [8*MAX_BYTES-1:0] data, data_nx;
    logic cmd_ok, is_wr, echo_ok, take, xfer_ok;
    always_comb begin
        cmd_ok = I_CMD >= ADDR_ROM_SZ'(1) && I_CMD <= ADDR_ROM_SZ'(6);
        is_wr = cmd == ADDR_ROM_SZ'(5);
        nbytes = (cmd == ADDR_ROM_SZ'(3) || cmd == ADDR_ROM_SZ'(4)) ? 3'd6 :
                 (cmd == ADDR_ROM_SZ'(2) || cmd == ADDR_ROM_SZ'(6)) ? 3'd2 : 3'd1;
        echo_ok = I_ADDR_ROM_ECHO == O_ADDR_ROM;
        take = I_I2C_RVALID && cnt < O_I2C_NBYTES;
        cnt_nx = take ? cnt + 3'd1 : cnt;
        data_nx = take ? {data[8*MAX_BYTES-9:0], I_I2C_RDATA} : data;
        // a byte arriving with DONE is already in cnt_nx
        xfer_ok = !O_I2C_RW || cnt_nx == O_I2C_NBYTES;
        state_nx = state;
        case (state)
            IDLE:     state_nx = I_CMD_VALID ? (cmd_ok ? RA_WAIT : ERR) : IDLE;
            RA_WAIT:  state_nx = RA_LATCH;
            RA_LATCH: state_nx = !echo_ok ? ERR : is_wr ? WD_WAIT : ISSUE;
            WD_WAIT:  state_nx = WD_LATCH;
            WD_LATCH: state_nx = echo_ok ? ISSUE : ERR;
            ISSUE:    state_nx = I_I2C_BUSY ? ISSUE : XFER;
            XFER:     state_nx = I_I2C_NACK ? ERR : I_I2C_DONE ? (xfer_ok ? DONE : ERR) : XFER;
            default:  state_nx = IDLE;
        endcase
    end
    assign O_BUSY = !(state == IDLE || state == DONE || state == ERR);
    assign O_DATA_VALID = state == DONE;
    assign O_ERR = state == ERR;
    always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd <= '0;
            reg_addr <= '0;
            wdata <= '0;
            cnt <= '0;
            data <= '0;
            O_DATA <= '0;
            O_ADDR_ROM <= '0;
            O_I2C_START <= 1'b0;
            O_I2C_RW <= 1'b0;
            O_I2C_REG_ADDR <= '0;
            O_I2C_WDATA <= '0;
            O_I2C_NBYTES <= '0;
        end else begin
            O_I2C_START <= state == ISSUE && !I_I2C_BUSY;
            if (state == IDLE && I_CMD_VALID && cmd_ok) begin
                cmd <= I_CMD;
                O_ADDR_ROM <= I_CMD;
            end
            if (state == RA_LATCH && echo_ok) begin
                reg_addr <= I_DATA_ROM;
                if (is_wr) O_ADDR_ROM <= cmd | ADDR_ROM_SZ'(8);
            end
            if (state == WD_LATCH && echo_ok) wdata <= I_DATA_ROM;
            if (state == ISSUE && !I_I2C_BUSY) begin
                O_I2C_RW <= !is_wr;
                O_I2C_REG_ADDR <= reg_addr;
                O_I2C_WDATA <= wdata;
                O_I2C_NBYTES <= nbytes;
                cnt <= '0;
                data <= '0;
            end
            if (state == XFER) begin
                cnt <= cnt_nx;
                data <= data_nx;
            end
            if (state_nx == DONE) O_DATA <= data_nx;
        end
    end
endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// tb_mpu_cmd_sequencer: scoreboard bench with a registered ROM model and a scripted I2C master
module tb_mpu_cmd_sequencer;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [3:0]  I_CMD = '0;
    logic        I_CMD_VALID = 1'b0;
    logic        O_BUSY, O_DATA_VALID, O_ERR, O_I2C_START, O_I2C_RW;
    logic [47:0] O_DATA;
    logic [3:0]  O_ADDR_ROM, I_ADDR_ROM_ECHO;
    logic [7:0]  I_DATA_ROM, O_I2C_REG_ADDR, O_I2C_WDATA;
    logic [2:0]  O_I2C_NBYTES;
    logic        I_I2C_BUSY = 1'b0, I_I2C_RVALID = 1'b0, I_I2C_DONE = 1'b0, I_I2C_NACK = 1'b0;
    logic [7:0]  I_I2C_RDATA = '0;

    mpu_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .I_CMD(I_CMD), .I_CMD_VALID(I_CMD_VALID), .O_BUSY(O_BUSY),
        .O_DATA(O_DATA), .O_DATA_VALID(O_DATA_VALID), .O_ERR(O_ERR), .O_ADDR_ROM(O_ADDR_ROM),
        .I_DATA_ROM(I_DATA_ROM), .I_ADDR_ROM_ECHO(I_ADDR_ROM_ECHO), .O_I2C_START(O_I2C_START),
        .O_I2C_RW(O_I2C_RW), .O_I2C_REG_ADDR(O_I2C_REG_ADDR), .O_I2C_WDATA(O_I2C_WDATA),
        .O_I2C_NBYTES(O_I2C_NBYTES), .I_I2C_BUSY(I_I2C_BUSY), .I_I2C_RDATA(I_I2C_RDATA),
        .I_I2C_RVALID(I_I2C_RVALID), .I_I2C_DONE(I_I2C_DONE), .I_I2C_NACK(I_I2C_NACK)
    );

    always #10 CLK = ~CLK;

    typedef struct {logic err; logic [47:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int tests = 0, fails = 0;
    logic [47:0] last_data = '0;
    logic prev_pulse = 1'b0;
    logic [7:0] rom [16];
    logic [3:0] echo_xor = '0;

    always @(posedge CLK) begin
        I_DATA_ROM <= rom[O_ADDR_ROM];
        I_ADDR_ROM_ECHO <= O_ADDR_ROM ^ echo_xor;
    end

    always @(negedge CLK) begin
        if (!RST && (O_DATA_VALID || O_ERR)) begin
            tests++;
            if (prev_pulse) begin
                fails++;
                $display("FAIL pulse_width: valid=%b err=%b high a second cycle, expected one-cycle pulse", O_DATA_VALID, O_ERR);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: valid=%b err=%b data=%h, expected no result", O_DATA_VALID, O_ERR, O_DATA);
            end else begin
                e = exp_q.pop_front();
                if (O_ERR !== e.err || O_DATA_VALID !== !e.err || O_DATA !== e.data) begin
                    fails++;
                    $display("FAIL result: err=%b valid=%b data=%h, expected err=%b valid=%b data=%h",
                             O_ERR, O_DATA_VALID, O_DATA, e.err, !e.err, e.data);
                end
            end
        end
        prev_pulse = !RST && (O_DATA_VALID || O_ERR);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_result(input logic err, input logic [47:0] d);
        exp_q.push_back('{err: err, data: d});
        if (!err) last_data = d;
    endtask

    task automatic send_cmd(input logic [3:0] c, input logic ok);
        I_CMD = c;
        I_CMD_VALID = 1'b1;
        tick();
        I_CMD_VALID = 1'b0;
        if (ok) begin
            tests++;
            if (O_ADDR_ROM !== c || O_BUSY !== 1'b1) begin
                fails++;
                $display("FAIL accept_%0h: addr=%h busy=%b, expected addr=%h busy=1", c, O_ADDR_ROM, O_BUSY, c);
            end
        end
    endtask

    task automatic wait_start(input int lat, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!O_I2C_START && n < 20);
        tests++;
        if (n != lat || O_I2C_START !== 1'b1) begin
            fails++;
            $display("FAIL start_%s: start=%b after %0d cycles, expected start=1 after %0d", nm, O_I2C_START, n, lat);
        end
    endtask

    task automatic rbyte(input logic [7:0] b);
        I_I2C_RDATA = b;
        I_I2C_RVALID = 1'b1;
        tick();
        I_I2C_RVALID = 1'b0;
    endtask

    task automatic done_pulse();
        I_I2C_DONE = 1'b1;
        tick();
        I_I2C_DONE = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: %0d results outstanding, expected 0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        tests++;
        if ({O_BUSY, O_DATA_VALID, O_ERR, O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG_ADDR,
             O_I2C_WDATA, O_I2C_NBYTES, O_DATA} !== '0) begin
            fails++;
            $display("FAIL reset_values: busy=%b addr=%h start=%b reg=%h data=%h, expected all 0",
                     O_BUSY, O_ADDR_ROM, O_I2C_START, O_I2C_REG_ADDR, O_DATA);
        end
        RST = 1'b0;
        last_data = '0;
    endtask

    task automatic test_reset_mid_xfer();
        send_cmd(4'd3, 1'b1);
        wait_start(3, "accel_pre_reset");
        rbyte(8'h01);
        rbyte(8'h02);
        RST = 1'b1;
        tick();
        tests++;
        if ({O_BUSY, O_DATA_VALID, O_ERR, O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG_ADDR,
             O_I2C_WDATA, O_I2C_NBYTES, O_DATA} !== '0) begin
            fails++;
            $display("FAIL reset_mid_xfer: busy=%b addr=%h rw=%b reg=%h nbytes=%0d, expected all 0",
                     O_BUSY, O_ADDR_ROM, O_I2C_RW, O_I2C_REG_ADDR, O_I2C_NBYTES);
        end
        RST = 1'b0;
        last_data = '0;
        rbyte(8'h03);
        done_pulse();
        repeat (3) tick();
    endtask

    task automatic test_check();
        expect_result(1'b0, 48'h68);
        send_cmd(4'd1, 1'b1);
        wait_start(3, "check");
        tests++;
        if ({O_I2C_RW, O_I2C_REG_ADDR, O_I2C_NBYTES} !== {1'b1, 8'h75, 3'd1}) begin
            fails++;
            $display("FAIL check_issue: rw=%b reg=%h nbytes=%0d, expected rw=1 reg=75 nbytes=1",
                     O_I2C_RW, O_I2C_REG_ADDR, O_I2C_NBYTES);
        end
        I_I2C_RDATA = 8'h68;
        I_I2C_RVALID = 1'b1;
        I_I2C_DONE = 1'b1;
        tick();
        I_I2C_RVALID = 1'b0;
        I_I2C_DONE = 1'b0;
        tests++;
        if (O_BUSY !== 1'b0 || O_DATA_VALID !== 1'b1) begin
            fails++;
            $display("FAIL check_complete: busy=%b valid=%b, expected busy=0 valid=1", O_BUSY, O_DATA_VALID);
        end
        drain("check");
    endtask

    task automatic test_fifo_en_busy();
        logic seen = 1'b0;
        I_I2C_BUSY = 1'b1;
        expect_result(1'b0, 48'h0);
        send_cmd(4'd5, 1'b1);
        repeat (8) begin
            tick();
            seen |= O_I2C_START;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL fifo_en_busy_hold: start=%b while master busy, expected 0", seen);
        end
        I_I2C_BUSY = 1'b0;
        wait_start(1, "fifo_en");
        tests++;
        if ({O_I2C_RW, O_I2C_REG_ADDR, O_I2C_WDATA, O_I2C_NBYTES} !== {1'b0, 8'h23, 8'hF8, 3'd1}) begin
            fails++;
            $display("FAIL fifo_en_issue: rw=%b reg=%h wdata=%h nbytes=%0d, expected rw=0 reg=23 wdata=f8 nbytes=1",
                     O_I2C_RW, O_I2C_REG_ADDR, O_I2C_WDATA, O_I2C_NBYTES);
        end
        tick();
        tests++;
        if (O_I2C_START !== 1'b0) begin
            fails++;
            $display("FAIL fifo_en_start_pulse: start=%b a second cycle, expected 0", O_I2C_START);
        end
        done_pulse();
        drain("fifo_en");
    endtask

    task automatic test_accel();
        expect_result(1'b0, 48'h010203040506);
        send_cmd(4'd3, 1'b1);
        wait_start(3, "accel");
        tests++;
        if ({O_I2C_RW, O_I2C_REG_ADDR, O_I2C_NBYTES} !== {1'b1, 8'h3B, 3'd6}) begin
            fails++;
            $display("FAIL accel_issue: rw=%b reg=%h nbytes=%0d, expected rw=1 reg=3b nbytes=6",
                     O_I2C_RW, O_I2C_REG_ADDR, O_I2C_NBYTES);
        end
        for (int i = 1; i <= 7; i++) rbyte(8'(i));
        done_pulse();
        drain("accel");
    endtask

    task automatic test_errors();
        logic [3:0] saved;
        logic seen;
        expect_result(1'b1, last_data);
        send_cmd(4'd2, 1'b1);
        wait_start(3, "tmp_short");
        rbyte(8'hAA);
        done_pulse();
        drain("tmp_short");
        expect_result(1'b1, last_data);
        send_cmd(4'd6, 1'b1);
        wait_start(3, "fifo_cnt");
        tests++;
        if ({O_I2C_REG_ADDR, O_I2C_NBYTES} !== {8'h72, 3'd2}) begin
            fails++;
            $display("FAIL fifo_cnt_issue: reg=%h nbytes=%0d, expected reg=72 nbytes=2", O_I2C_REG_ADDR, O_I2C_NBYTES);
        end
        rbyte(8'h11);
        rbyte(8'h22);
        I_I2C_NACK = 1'b1;
        I_I2C_DONE = 1'b1;
        tick();
        I_I2C_NACK = 1'b0;
        I_I2C_DONE = 1'b0;
        drain("nack_done");
        echo_xor = 4'h2;
        expect_result(1'b1, last_data);
        send_cmd(4'd1, 1'b1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= O_I2C_START;
        end
        echo_xor = '0;
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL echo_no_start: start=%b, expected 0", seen);
        end
        drain("echo");
        saved = O_ADDR_ROM;
        expect_result(1'b1, last_data);
        send_cmd(4'h9, 1'b0);
        tests++;
        if (O_ERR !== 1'b1 || O_ADDR_ROM !== saved) begin
            fails++;
            $display("FAIL bad_code: err=%b addr=%h, expected err=1 addr=%h", O_ERR, O_ADDR_ROM, saved);
        end
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= O_I2C_START;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bad_code_no_start: start=%b, expected 0", seen);
        end
        drain("bad_code");
    endtask

    task automatic test_ignored_cmds();
        expect_result(1'b0, 48'hA1A2A3A4A5A6);
        send_cmd(4'd4, 1'b1);
        I_CMD_VALID = 1'b1;
        I_CMD = 4'd1;
        wait_start(3, "gyro");
        tests++;
        if ({O_I2C_REG_ADDR, O_I2C_NBYTES} !== {8'h43, 3'd6}) begin
            fails++;
            $display("FAIL gyro_issue: reg=%h nbytes=%0d, expected reg=43 nbytes=6", O_I2C_REG_ADDR, O_I2C_NBYTES);
        end
        for (int i = 1; i <= 6; i++) begin
            I_CMD = 4'(i);
            rbyte(8'hA0 + 8'(i));
        end
        I_CMD_VALID = 1'b0;
        done_pulse();
        drain("gyro");
        repeat (5) tick();
        tests++;
        if (O_BUSY !== 1'b0) begin
            fails++;
            $display("FAIL ignored_cmds_idle: busy=%b, expected 0", O_BUSY);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[1] = 8'h75;
        rom[2] = 8'h41;
        rom[3] = 8'h3B;
        rom[4] = 8'h43;
        rom[5] = 8'h23;
        rom[6] = 8'h72;
        rom[13] = 8'hF8;
        test_reset();
        test_reset_mid_xfer();
        test_check();
        test_fifo_en_busy();
        test_accel();
        test_errors();
        test_ignored_cmds();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
